// File: rtl/serial_add_arb.sv
// Round-robin scheduler sharing one bit-serial adder among NREQ requesters.
// Optional completed-operation counter enabled by `SERIAL_ADD_ARB_OPCNT_EN.
`timescale 1ns/1ps

module serial_add_arb #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 8,
    parameter int ADD_LAT = 9
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   a_in,
    input  logic [NREQ*WIDTH-1:0]   b_in,
    output logic [NREQ-1:0]         ack,
    output logic [WIDTH-1:0]        rsp_data,
    output logic                    busy,
    output logic                    add_en,
    output logic [WIDTH-1:0]        add_a,
    output logic [WIDTH-1:0]        add_b,
    input  logic [WIDTH-1:0]        add_sum,
    output logic [15:0]             op_count
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int LAT_W = $clog2(ADD_LAT);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(ADD_LAT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NREQ - 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [IDX_W-1:0]   gnt_idx_reg, gnt_idx_next;
    logic [LAT_W-1:0]   lat_cnt_reg, lat_cnt_next;
    logic [WIDTH-1:0]   add_a_reg, add_a_next;
    logic [WIDTH-1:0]   add_b_reg, add_b_next;
    logic [WIDTH-1:0]   rsp_data_reg, rsp_data_next;

    logic [WIDTH-1:0]   a_arr [NREQ];
    logic [WIDTH-1:0]   b_arr [NREQ];
    logic [IDX_W-1:0]   rot_idx [NREQ];
    logic [NREQ-1:0]    rot_req;
    logic [IDX_W-1:0]   pick_idx;

    // rot_req[k] is the request k positions above rr_ptr (mod NREQ)
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
        logic [IDX_W:0] pos_sum;

        assign a_arr[gi]   = a_in[gi*WIDTH +: WIDTH];
        assign b_arr[gi]   = b_in[gi*WIDTH +: WIDTH];
        assign pos_sum     = {1'b0, rr_ptr_reg} + (IDX_W+1)'(gi);
        assign rot_idx[gi] = (pos_sum >= (IDX_W+1)'(NREQ))
                             ? IDX_W'(pos_sum - (IDX_W+1)'(NREQ))
                             : pos_sum[IDX_W-1:0];
        assign rot_req[gi] = req[rot_idx[gi]];
        assign ack[gi]     = (state_reg == DONE) && (gnt_idx_reg == IDX_W'(gi));
    end

    // Descending scan so the lowest rotated offset wins
    always_comb begin
        pick_idx = rr_ptr_reg;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot_req[k]) begin
                pick_idx = rot_idx[k];
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        rr_ptr_next   = rr_ptr_reg;
        gnt_idx_next  = gnt_idx_reg;
        lat_cnt_next  = lat_cnt_reg;
        add_a_next    = add_a_reg;
        add_b_next    = add_b_reg;
        rsp_data_next = rsp_data_reg;
        busy          = 1'b0;
        add_en        = 1'b0;

        case (state_reg)
            IDLE: begin
                if (|req) begin
                    gnt_idx_next = pick_idx;
                    add_a_next   = a_arr[pick_idx];
                    add_b_next   = b_arr[pick_idx];
                    state_next   = LOAD;
                end
            end
            LOAD: begin
                busy         = 1'b1;
                add_en       = 1'b1;
                lat_cnt_next = '0;
                state_next   = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (lat_cnt_reg == LAT_LAST) begin
                    rsp_data_next = add_sum;
                    state_next    = DONE;
                end else begin
                    lat_cnt_next = lat_cnt_reg + LAT_W'(1);
                end
            end
            DONE: begin
                busy        = 1'b1;
                rr_ptr_next = (gnt_idx_reg == IDX_LAST) ? '0 : gnt_idx_reg + IDX_W'(1);
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            rr_ptr_reg   <= '0;
            gnt_idx_reg  <= '0;
            lat_cnt_reg  <= '0;
            add_a_reg    <= '0;
            add_b_reg    <= '0;
            rsp_data_reg <= '0;
        end else begin
            state_reg    <= state_next;
            rr_ptr_reg   <= rr_ptr_next;
            gnt_idx_reg  <= gnt_idx_next;
            lat_cnt_reg  <= lat_cnt_next;
            add_a_reg    <= add_a_next;
            add_b_reg    <= add_b_next;
            rsp_data_reg <= rsp_data_next;
        end
    end

    assign add_a    = add_a_reg;
    assign add_b    = add_b_reg;
    assign rsp_data = rsp_data_reg;

`ifdef SERIAL_ADD_ARB_OPCNT_EN
    logic [15:0] op_count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count_reg <= '0;
        end else if (state_reg == DONE) begin
            op_count_reg <= op_count_reg + 16'd1;
        end
    end

    assign op_count = op_count_reg;
`else
    assign op_count = '0;
`endif

endmodule

// File: tb/tb_serial_add_arb.sv
// Directed bench for serial_add_arb with a stub adder that only shows a+b
// once the bit-serial latency has elapsed after add_en.
`timescale 1ns/1ps

module tb_serial_add_arb;

    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int LAT  = 9;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NREQ-1:0]      req;
    logic [NREQ*W-1:0]    a_in;
    logic [NREQ*W-1:0]    b_in;
    logic [NREQ-1:0]      ack;
    logic [W-1:0]         rsp_data;
    logic                 busy;
    logic                 add_en;
    logic [W-1:0]         add_a;
    logic [W-1:0]         add_b;
    logic [W-1:0]         add_sum;
    logic [15:0]          op_count;

    serial_add_arb #(.NREQ(NREQ), .WIDTH(W), .ADD_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in),
        .ack(ack), .rsp_data(rsp_data), .busy(busy), .add_en(add_en),
        .add_a(add_a), .add_b(add_b), .add_sum(add_sum), .op_count(op_count)
    );

    always #5 clk = ~clk;

    // Stub adder: result appears W cycles after the enable edge, zero before
    logic [W-1:0] stub_res = '0;
    int           stub_cnt = 20;
    always @(posedge clk) begin
        if (add_en) begin
            stub_res <= add_a + add_b;
            stub_cnt <= 0;
        end else if (stub_cnt < 20) begin
            stub_cnt <= stub_cnt + 1;
        end
    end
    assign add_sum = (stub_cnt >= W) ? stub_res : '0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("ack_en_overlap", {31'b0, (ack != '0) && add_en}, 32'd0);
            chk("ack_onehot0", {31'b0, $onehot0(ack)}, 32'd1);
        end
    end

    typedef struct {
        int         idx;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] sum;
    } vec_t;

    vec_t vecs [6];

    // n counts edges after the call; n_ack is the edge after which ack is seen
    task automatic wait_ack(output int n_ack, output int en_n, output int en_cnt,
                            output logic [7:0] ca, output logic [7:0] cb);
        bit seen = 1'b0;
        n_ack = -1; en_n = -1; en_cnt = 0; ca = '0; cb = '0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (add_en) begin
                en_cnt++;
                if (en_n < 0) begin
                    en_n = n; ca = add_a; cb = add_b;
                end
            end
            if (ack != '0) begin
                n_ack = n; seen = 1'b1;
                break;
            end
        end
        chk("ack_seen", {31'b0, seen}, 32'd1);
    endtask

    // Caller guarantees the DUT is IDLE at the time of the call
    task automatic run_op(input int idx, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] sum, input string tag);
        int n_ack, en_n, en_cnt;
        logic [7:0] ca, cb;
        req = '0;
        a_in[idx*W +: W] = a;
        b_in[idx*W +: W] = b;
        req[idx] = 1'b1;
        wait_ack(n_ack, en_n, en_cnt, ca, cb);
        chk({tag, "_en_count"}, en_cnt, 1);
        chk({tag, "_en_cycle"}, en_n, 1);
        chk({tag, "_add_a"}, {24'b0, ca}, {24'b0, a});
        chk({tag, "_add_b"}, {24'b0, cb}, {24'b0, b});
        chk({tag, "_latency"}, n_ack, LAT + 2);
        chk({tag, "_ack"}, {28'b0, ack}, 32'd1 << idx);
        chk({tag, "_rsp"}, {24'b0, rsp_data}, {24'b0, sum});
        $display("op %s: req %0d a=%02h b=%02h -> ack=%b rsp=%02h lat=%0d",
                 tag, idx, a, b, ack, rsp_data, n_ack);
        req = '0;
        @(posedge clk); #1;
        chk({tag, "_ack_clear"}, {28'b0, ack}, 32'd0);
        chk({tag, "_rsp_hold"}, {24'b0, rsp_data}, {24'b0, sum});
        chk({tag, "_idle"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        automatic int         order [5] = '{0, 1, 2, 3, 0};
        automatic logic [7:0] rr_a [4]  = '{8'h10, 8'h20, 8'h30, 8'h40};
        automatic logic [7:0] rr_b [4]  = '{8'h01, 8'h02, 8'h03, 8'h04};
        automatic logic [7:0] rr_s [4]  = '{8'h11, 8'h22, 8'h33, 8'h44};
        int n_ack, en_n, en_cnt;
        logic [7:0] ca, cb;

        vecs[0] = '{0, 8'h05, 8'h03, 8'h08};
        vecs[1] = '{1, 8'h7F, 8'h01, 8'h80};
        vecs[2] = '{2, 8'hA5, 8'h5A, 8'hFF};
        vecs[3] = '{3, 8'h80, 8'h80, 8'h00};
        vecs[4] = '{2, 8'hC8, 8'h64, 8'h2C};
        vecs[5] = '{3, 8'hFF, 8'h02, 8'h01};

        req = '0; a_in = '0; b_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", {28'b0, ack}, 32'd0);
        chk("rst_rsp", {24'b0, rsp_data}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_add_en", {31'b0, add_en}, 32'd0);
        chk("rst_add_a", {24'b0, add_a}, 32'd0);
        chk("rst_add_b", {24'b0, add_b}, 32'd0);
        chk("rst_op_count", {16'b0, op_count}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_no_req", {31'b0, busy}, 32'd0);

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].idx, vecs[i].a, vecs[i].b, vecs[i].sum, $sformatf("vec%0d", i));
        end

        // Round-robin: last vector served requester 3, so 0 must win next
        for (int i = 0; i < NREQ; i++) begin
            a_in[i*W +: W] = rr_a[i];
            b_in[i*W +: W] = rr_b[i];
        end
        req = '1;
        for (int k = 0; k < 5; k++) begin
            wait_ack(n_ack, en_n, en_cnt, ca, cb);
            chk($sformatf("rr%0d_ack", k), {28'b0, ack}, 32'd1 << order[k]);
            chk($sformatf("rr%0d_rsp", k), {24'b0, rsp_data}, {24'b0, rr_s[order[k]]});
            chk($sformatf("rr%0d_spacing", k), n_ack, (k == 0) ? LAT + 2 : LAT + 3);
            chk($sformatf("rr%0d_en_count", k), en_cnt, 1);
            $display("rr %0d: ack=%b rsp=%02h cycles=%0d", k, ack, rsp_data, n_ack);
            if (k == 4) req = '0;
        end
        @(posedge clk); #1;

        // Withdraw req[2] during RUN, raise req[1] late
        a_in[2*W +: W] = 8'h3C; b_in[2*W +: W] = 8'h0F;
        a_in[1*W +: W] = 8'h21; b_in[1*W +: W] = 8'h12;
        req = 4'b0100;
        @(posedge clk); #1;
        chk("wd_load_en", {31'b0, add_en}, 32'd1);
        chk("wd_add_a", {24'b0, add_a}, 32'h3C);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("wd_busy", {31'b0, busy}, 32'd1);
        req = 4'b0010;
        wait_ack(n_ack, en_n, en_cnt, ca, cb);
        chk("wd_ack", {28'b0, ack}, 32'b0100);
        chk("wd_rsp", {24'b0, rsp_data}, 32'h4B);
        chk("wd_remaining", n_ack, LAT + 2 - 3);
        chk("wd_no_regrant", en_cnt, 0);
        $display("withdraw: ack=%b rsp=%02h", ack, rsp_data);
        wait_ack(n_ack, en_n, en_cnt, ca, cb);
        chk("late_ack", {28'b0, ack}, 32'b0010);
        chk("late_rsp", {24'b0, rsp_data}, 32'h33);
        chk("late_add_a", {24'b0, ca}, 32'h21);
        chk("late_en_cycle", en_n, 2);
        chk("late_latency", n_ack - en_n + 1, LAT + 2);
        $display("late req: ack=%b rsp=%02h", ack, rsp_data);
        req = '0;
        @(posedge clk); #1;
`ifdef SERIAL_ADD_ARB_OPCNT_EN
        chk("op_count_13", {16'b0, op_count}, 32'd13);
`else
        chk("op_count_off", {16'b0, op_count}, 32'd0);
`endif

        // Reset at lat_cnt==4, with a different request pending
        a_in[0*W +: W] = 8'h11; b_in[0*W +: W] = 8'h22;
        req = 4'b0001;
        @(posedge clk); #1;
        chk("mr_load_en", {31'b0, add_en}, 32'd1);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        req = 4'b0010;
        a_in[1*W +: W] = 8'h33; b_in[1*W +: W] = 8'h44;
        #1;
        chk("mr_ack", {28'b0, ack}, 32'd0);
        chk("mr_rsp", {24'b0, rsp_data}, 32'd0);
        chk("mr_busy", {31'b0, busy}, 32'd0);
        chk("mr_add_en", {31'b0, add_en}, 32'd0);
        chk("mr_add_a", {24'b0, add_a}, 32'd0);
        chk("mr_add_b", {24'b0, add_b}, 32'd0);
        chk("mr_op_count", {16'b0, op_count}, 32'd0);
        $display("mid-run reset: ack=%b busy=%b add_a=%02h", ack, busy, add_a);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("mr_hold_ack", {28'b0, ack}, 32'd0);
            chk("mr_hold_busy", {31'b0, busy}, 32'd0);
        end
        rst_n = 1'b1;
        run_op(1, 8'h33, 8'h44, 8'h77, "after_rst");
        run_op(2, 8'h01, 8'h01, 8'h02, "cnt_a");
        run_op(0, 8'h40, 8'h40, 8'h80, "cnt_b");
`ifdef SERIAL_ADD_ARB_OPCNT_EN
        chk("op_count_3", {16'b0, op_count}, 32'd3);
`else
        chk("op_count_zero", {16'b0, op_count}, 32'd0);
`endif
        $display("op_count=%0d", op_count);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
